term_ctrl: RTL and testbench
============================

Name: term_ctrl

Overview:
- Terminal controller directly upstream of the video/VRAM block.
- Consumes received bytes over a valid/ready stream and drives the VRAM controller port (address, data, clock enable, write/read).
- Maintains the cursor and interprets control characters. Scrolls by copying VRAM rows, and drives the reverse-video bell signal.
- The VRAM controller-port address doubles as the cursor position when the block is idle.

Parameters:
- BEL_TICKS, 1200000, number of clock cycles o_reversev stays high per BEL (100 ms at 12 MHz).
- FILL_CHAR, 8'h20, byte written by clear and scroll fill operations.

Ports:
- i_clk  input  1  system clock (12 MHz); also drives the VRAM controller-port clock.
- i_rst  input  1  synchronous, active-high reset.
- i_data  input  8  received byte.
- i_valid  input  1  i_data valid.
- o_ready  output  1  byte accepted on a clock edge where i_valid && o_ready.
- o_vram_addr  output  11  VRAM address {5'y, 6'x}.
- o_vram_din  output  8  VRAM write data.
- i_vram_dout  input  8  VRAM read data; valid the cycle after a read cycle (ce=1, wre=0).
- o_vram_ce  output  1  VRAM clock enable.
- o_vram_wre  output  1  VRAM write (1) / read (0).
- o_reversev  output  1  reverse video (visual bell).

Behaviour:
- Reset: one clock, active-high, synchronous; reset has priority over everything. Reset aborts any operation in progress and enters CLEAR.
- Reset values: cursor x=0,y=0; o_vram_addr=0; o_vram_ce=0; o_vram_wre=0; o_vram_din=FILL_CHAR; o_ready=0; o_reversev=0; bell counter=0.
- FSM states: CLEAR, IDLE, WRITE, SCR_RD, SCR_WT, SCR_WR, SCR_FILL.
- o_ready=1 only in IDLE.
- IDLE outputs: o_vram_ce=0, o_vram_wre=0, o_vram_addr={y,x}.
- CLEAR: writes FILL_CHAR to addresses 0..2047, one per cycle (ce=1, wre=1), 2048 cycles. Then x=0, y=0, go to IDLE.
- Accepted byte, decoded in IDLE:
  - 0x20..0x7E: go to WRITE. In WRITE, for one cycle: ce=1, wre=1, addr={y,x}, din=byte. At the end of WRITE:
    - x<63: x+1, go to IDLE.
    - x==63 and y<31: x=0, y+1, go to IDLE.
    - x==63 and y==31: x=0, go to SCR_RD.
  - 0x0D CR: x=0. Stay in IDLE; o_ready remains 1.
  - 0x0A LF: if y<31, y+1 and stay in IDLE; else go to SCR_RD. x is unchanged.
  - 0x08 BS: if x>0, x-1; nothing is erased. At x=0, no change; no reverse wrap.
  - 0x0C FF: go to CLEAR, then home to (0,0).
  - 0x07 BEL: bell counter loads BEL_TICKS and o_reversev=1 from the next cycle. Stay in IDLE.
  - Any other byte: consumed and ignored.
- Bell:
  - The counter decrements every cycle while nonzero, independent of the FSM, including during scroll and clear.
  - o_reversev = (counter != 0), registered.
  - A BEL while the bell is active reloads BEL_TICKS.
  - o_reversev must be high for exactly BEL_TICKS cycles after an isolated BEL.
- Scroll: source pointer src runs from 64 to 2047. Per cell:
  - SCR_RD: ce=1, wre=0, addr=src.
  - SCR_WT: ce=0; capture i_vram_dout at the end of the cycle.
  - SCR_WR: ce=1, wre=1, addr=src-64, din=captured byte; src+1.
  - After src=2047, go to SCR_FILL.
- SCR_FILL: writes FILL_CHAR to 1984..2047, one per cycle. Then y=31 (x already set), go to IDLE.
- Scroll total: 1984×3 + 64 = 6016 cycles with o_ready=0.
- All address arithmetic is 11-bit; src-64 never underflows.
- i_valid while o_ready=0 is not accepted; upstream holds the byte.
- Bytes are never dropped or duplicated.

Test Plan:
- Reset held 1 cycle, then released → o_ready=0 for exactly 2048 cycles; every cell reads 0x20; then o_ready=1 and o_vram_addr=0.
- Send 'A'(0x41) then 'B' after clear → VRAM[0]=0x41, VRAM[1]=0x42; o_ready low exactly 1 cycle per byte; idle o_vram_addr=2.
- Cursor at (63,5), send 'Z' → VRAM[0x17F]=0x5A; idle addr=0x180 (x=0,y=6). Then BS, BS → addr stays at 0x180 after the first BS (x=0 clamp).
- Fill row 1 with 'x' and row 31 with 'q', cursor (10,31), send LF → o_ready low for 6016 cycles; row 0 = 'x' ×64, row 30 = 'q', row 31 = 0x20 ×64; idle addr=0x7CA.
- BEL_TICKS=10: send BEL, then BEL again 5 cycles later → o_reversev high for 15 contiguous cycles, then 0; o_ready never drops.
- Assert i_rst mid-scroll (cycle 3000), with i_valid held high with 0x41 throughout → scroll aborts; full CLEAR runs; 0x41 is accepted only after CLEAR and written at address 0.

Source files
------------

// File: rtl/term_ctrl.sv
// Terminal controller: turns a received byte stream into VRAM writes, tracks the
// cursor, scrolls by copying rows up one line, and times the reverse-video bell.
module term_ctrl #(
  parameter int         BEL_TICKS = 1200000,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [10:0] o_vram_addr,
  output logic [7:0]  o_vram_din,
  input  logic [7:0]  i_vram_dout,
  output logic        o_vram_ce,
  output logic        o_vram_wre,
  output logic        o_reversev
);

  localparam int BW = $clog2(BEL_TICKS + 1);

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    WRITE,
    SCR_RD,
    SCR_WT,
    SCR_WR,
    SCR_FILL
  } state_t;

  state_t         state_reg, state_next;
  logic [5:0]     x_reg, x_next;
  logic [4:0]     y_reg, y_next;
  logic [10:0]    ptr_reg, ptr_next;
  logic [7:0]     char_reg, char_next;
  logic [7:0]     rd_reg, rd_next;
  logic [BW-1:0]  bell_reg, bell_next;
  logic           rev_reg;
  logic           accept;
  logic           bell_hit;

  assign accept = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= CLEAR;
      x_reg     <= '0;
      y_reg     <= '0;
      ptr_reg   <= '0;
      char_reg  <= '0;
      rd_reg    <= '0;
      bell_reg  <= '0;
      rev_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      ptr_reg   <= ptr_next;
      char_reg  <= char_next;
      rd_reg    <= rd_next;
      bell_reg  <= bell_next;
      rev_reg   <= (bell_next != '0);
    end
  end

  // Next-state logic; ptr_reg serves as the clear address, the scroll source
  // pointer and the fill address depending on the state.
  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    ptr_next   = ptr_reg;
    char_next  = char_reg;
    rd_next    = rd_reg;
    bell_hit   = 1'b0;
    case (state_reg)
      CLEAR: begin
        ptr_next = ptr_reg + 11'd1;
        if (ptr_reg == 11'd2047) begin
          state_next = IDLE;
          x_next     = '0;
          y_next     = '0;
          ptr_next   = '0;
        end
      end
      IDLE: begin
        if (accept) begin
          if (i_data >= 8'h20 && i_data <= 8'h7E) begin
            char_next  = i_data;
            state_next = WRITE;
          end else begin
            case (i_data)
              8'h0D: x_next = '0;
              8'h0A: begin
                if (y_reg != 5'd31) begin
                  y_next = y_reg + 5'd1;
                end else begin
                  state_next = SCR_RD;
                  ptr_next   = 11'd64;
                end
              end
              8'h08: begin
                if (x_reg != 6'd0) x_next = x_reg - 6'd1;
              end
              8'h0C: begin
                state_next = CLEAR;
                ptr_next   = '0;
              end
              8'h07: bell_hit = 1'b1;
              default: ;
            endcase
          end
        end
      end
      WRITE: begin
        state_next = IDLE;
        if (x_reg != 6'd63) begin
          x_next = x_reg + 6'd1;
        end else begin
          x_next = '0;
          if (y_reg != 5'd31) begin
            y_next = y_reg + 5'd1;
          end else begin
            state_next = SCR_RD;
            ptr_next   = 11'd64;
          end
        end
      end
      SCR_RD: state_next = SCR_WT;
      SCR_WT: begin
        rd_next    = i_vram_dout;
        state_next = SCR_WR;
      end
      SCR_WR: begin
        ptr_next   = ptr_reg + 11'd1;
        state_next = SCR_RD;
        if (ptr_reg == 11'd2047) begin
          state_next = SCR_FILL;
          ptr_next   = 11'd1984;
        end
      end
      SCR_FILL: begin
        ptr_next = ptr_reg + 11'd1;
        if (ptr_reg == 11'd2047) begin
          state_next = IDLE;
          y_next     = 5'd31;
          ptr_next   = '0;
        end
      end
      default: state_next = CLEAR;
    endcase

    // The bell runs regardless of what the FSM is doing.
    if (bell_hit) begin
      bell_next = BW'(BEL_TICKS);
    end else if (bell_reg != '0) begin
      bell_next = bell_reg - BW'(1);
    end else begin
      bell_next = bell_reg;
    end
  end

  // VRAM port decode; while reset is asserted the port shows its idle values.
  always_comb begin
    o_ready     = 1'b0;
    o_vram_addr = {y_reg, x_reg};
    o_vram_din  = FILL_CHAR;
    o_vram_ce   = 1'b0;
    o_vram_wre  = 1'b0;
    if (i_rst) begin
      o_vram_addr = '0;
    end else begin
      case (state_reg)
        CLEAR: begin
          o_vram_ce   = 1'b1;
          o_vram_wre  = 1'b1;
          o_vram_addr = ptr_reg;
        end
        IDLE: o_ready = 1'b1;
        WRITE: begin
          o_vram_ce  = 1'b1;
          o_vram_wre = 1'b1;
          o_vram_din = char_reg;
        end
        SCR_RD: begin
          o_vram_ce   = 1'b1;
          o_vram_addr = ptr_reg;
        end
        SCR_WT: o_vram_addr = ptr_reg;
        SCR_WR: begin
          o_vram_ce   = 1'b1;
          o_vram_wre  = 1'b1;
          o_vram_addr = ptr_reg - 11'd64;
          o_vram_din  = rd_reg;
        end
        SCR_FILL: begin
          o_vram_ce   = 1'b1;
          o_vram_wre  = 1'b1;
          o_vram_addr = ptr_reg;
        end
        default: ;
      endcase
    end
  end

  assign o_reversev = rev_reg;

endmodule

// File: tb/tb_term_ctrl.sv
// Testbench for term_ctrl: VRAM model, write scoreboard fed by a terminal model,
// and directed checks of cursor, scroll, bell and reset behaviour.
module tb_term_ctrl;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic [10:0] o_vram_addr;
  logic [7:0]  o_vram_din;
  logic [7:0]  i_vram_dout;
  logic        o_vram_ce;
  logic        o_vram_wre;
  logic        o_reversev;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b1;

  logic [18:0] exp_q[$];
  logic [7:0]  exp_mem[2048];
  logic [7:0]  vram[2048];
  int cur_x = 0;
  int cur_y = 0;

  always #5 clk = ~clk;

  term_ctrl #(.BEL_TICKS(10), .FILL_CHAR(8'h20)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_vram_addr(o_vram_addr), .o_vram_din(o_vram_din),
    .i_vram_dout(i_vram_dout), .o_vram_ce(o_vram_ce), .o_vram_wre(o_vram_wre),
    .o_reversev(o_reversev)
  );

  // Behavioural VRAM with one-cycle read latency.
  initial for (int a = 0; a < 2048; a++) vram[a] = 8'hEE;
  always @(posedge clk) begin
    if (o_vram_ce) begin
      if (o_vram_wre) vram[o_vram_addr] <= o_vram_din;
      else            i_vram_dout <= vram[o_vram_addr];
    end
  end

  // Write monitor: every VRAM write must match the head of the expected queue.
  always @(negedge clk) begin
    logic [18:0] e;
    if (check_en && !i_rst && o_vram_ce && o_vram_wre) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL vram_wr: unexpected write addr=0x%03h data=0x%02h, none expected",
                 o_vram_addr, o_vram_din);
      end else begin
        e = exp_q.pop_front();
        if ({o_vram_addr, o_vram_din} != e) begin
          errors++;
          $display("FAIL vram_wr: got addr=0x%03h data=0x%02h, expected addr=0x%03h data=0x%02h",
                   o_vram_addr, o_vram_din, e[18:8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input int a, input int d);
    logic [10:0] a11;
    logic [7:0]  d8;
    a11 = a[10:0];
    d8  = d[7:0];
    exp_q.push_back({a11, d8});
    exp_mem[a] = d8;
  endtask

  task automatic push_clear();
    for (int a = 0; a < 2048; a++) push_wr(a, 8'h20);
    cur_x = 0;
    cur_y = 0;
  endtask

  task automatic push_scroll();
    for (int a = 0; a < 1984; a++) push_wr(a, int'(exp_mem[a + 64]));
    for (int a = 1984; a < 2048; a++) push_wr(a, 8'h20);
    cur_y = 31;
  endtask

  task automatic model(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(cur_y * 64 + cur_x, int'(b));
      if (cur_x < 63) cur_x++;
      else begin
        cur_x = 0;
        if (cur_y < 31) cur_y++;
        else push_scroll();
      end
    end else begin
      case (b)
        8'h0D: cur_x = 0;
        8'h0A: if (cur_y < 31) cur_y++; else push_scroll();
        8'h08: if (cur_x > 0) cur_x--;
        8'h0C: push_clear();
        default: ;
      endcase
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    model(b);
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = b;
    n = 0;
    while (!o_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: byte 0x%02h not accepted", b);
    end
    @(posedge clk);
    #1 i_valid = 1'b0;
    $display("tx byte=0x%02h cursor=(%0d,%0d)", b, cur_x, cur_y);
  endtask

  task automatic wait_idle(output int lowcnt);
    lowcnt = 0;
    @(negedge clk);
    while (!o_ready && lowcnt < 20000) begin
      lowcnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc;
    int hi;
    bit fell, gap, drop;
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_data = 8'h00;
    push_clear();

    @(posedge clk);
    #1;
    chk("rst_ready", int'(o_ready), 0);
    chk("rst_ce", int'(o_vram_ce), 0);
    chk("rst_wre", int'(o_vram_wre), 0);
    chk("rst_addr", int'(o_vram_addr), 0);
    chk("rst_din", int'(o_vram_din), 32'h20);
    chk("rst_rev", int'(o_reversev), 0);
    i_rst = 1'b0;
    wait_idle(lc);
    chk("clear_len", lc, 2048);
    chk("clear_addr", int'(o_vram_addr), 0);
    chk("clear_cell0", int'(vram[0]), 32'h20);
    chk("clear_cell2047", int'(vram[2047]), 32'h20);

    send(8'h41); wait_idle(lc); chk("A_low", lc, 1);
    send(8'h42); wait_idle(lc); chk("B_low", lc, 1);
    chk("AB_addr", int'(o_vram_addr), 2);
    chk("AB_mem0", int'(vram[0]), 32'h41);
    chk("AB_mem1", int'(vram[1]), 32'h42);

    send(8'h0D); wait_idle(lc); chk("CR_low", lc, 0);
    for (int i = 0; i < 5; i++) begin send(8'h0A); wait_idle(lc); end
    chk("row5_addr", int'(o_vram_addr), 32'h140);
    for (int i = 0; i < 63; i++) begin send(8'h79); wait_idle(lc); end
    chk("x63_addr", int'(o_vram_addr), 32'h17F);
    send(8'h5A); wait_idle(lc);
    chk("Z_mem", int'(vram[11'h17F]), 32'h5A);
    chk("Z_wrap_addr", int'(o_vram_addr), 32'h180);
    send(8'h08); wait_idle(lc); chk("BS1_addr", int'(o_vram_addr), 32'h180);
    send(8'h08); wait_idle(lc); chk("BS2_addr", int'(o_vram_addr), 32'h180);
    send(8'h79); wait_idle(lc);
    send(8'h08); wait_idle(lc); chk("BS3_addr", int'(o_vram_addr), 32'h180);
    chk("BS_no_erase", int'(vram[11'h180]), 32'h79);

    send(8'h0C); wait_idle(lc); chk("FF_len", lc, 2048);
    chk("FF_addr", int'(o_vram_addr), 0);
    send(8'h0A); wait_idle(lc);
    for (int i = 0; i < 64; i++) begin send(8'h78); wait_idle(lc); end
    for (int i = 0; i < 29; i++) begin send(8'h0A); wait_idle(lc); end
    for (int i = 0; i < 63; i++) begin send(8'h71); wait_idle(lc); end
    send(8'h0D); wait_idle(lc);
    for (int i = 0; i < 10; i++) begin send(8'h71); wait_idle(lc); end
    chk("pre_scroll_addr", int'(o_vram_addr), 32'h7CA);
    send(8'h0A); wait_idle(lc);
    chk("scroll_len", lc, 6016);
    chk("scroll_addr", int'(o_vram_addr), 32'h7CA);
    chk("row0_first", int'(vram[0]), 32'h78);
    chk("row0_last", int'(vram[63]), 32'h78);
    chk("row30_q", int'(vram[30 * 64 + 7]), 32'h71);
    chk("row31_first", int'(vram[1984]), 32'h20);
    chk("row31_last", int'(vram[2047]), 32'h20);
    chk("scroll_q_empty", exp_q.size(), 0);

    // Two BELs five cycles apart should merge into one 15-cycle pulse.
    send(8'h07);
    hi = 0; fell = 0; gap = 0; drop = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) chk("bell_first", int'(o_reversev), 1);
      if (o_reversev) begin
        hi++;
        if (fell) gap = 1;
      end else if (hi > 0) begin
        fell = 1;
      end
      if (!o_ready) drop = 1;
      if (i == 4) begin i_valid = 1'b1; i_data = 8'h07; end
      else i_valid = 1'b0;
    end
    $display("tx byte=0x07 (second bell)");
    chk("bell_high_cycles", hi, 15);
    chk("bell_gap", int'(gap), 0);
    chk("bell_ready_drop", int'(drop), 0);
    chk("bell_end", int'(o_reversev), 0);

    // Reset in the middle of a scroll with a byte held on the input.
    chk("pre_abort_q", exp_q.size(), 0);
    check_en = 1'b0;
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 8'h0A;
    lc = 0;
    while (!o_ready && lc < 100) begin @(negedge clk); lc++; end
    @(posedge clk);
    #1 i_data = 8'h41;
    $display("tx byte=0x0a (scroll to be aborted)");
    for (int i = 0; i < 3000; i++) @(negedge clk);
    #1 i_rst = 1'b1;
    exp_q.delete();
    push_clear();
    model(8'h41);
    check_en = 1'b1;
    chk("abort_ready", int'(o_ready), 0);
    @(posedge clk);
    #1 i_rst = 1'b0;
    lc = 0;
    @(negedge clk);
    while (!o_ready && lc < 20000) begin lc++; @(negedge clk); end
    chk("abort_clear_len", lc, 2048);
    @(posedge clk);
    #1 i_valid = 1'b0;
    $display("tx byte=0x41 (held through reset)");
    wait_idle(lc);
    chk("abort_addr", int'(o_vram_addr), 1);
    chk("abort_mem0", int'(vram[0]), 32'h41);
    chk("abort_mem1", int'(vram[1]), 32'h20);
    chk("final_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
